// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the monarch/serf pair.
package spi_pkg;

  localparam int SPI_W = 16;
  localparam logic SCLK_IDLE = 1'b1;

  typedef enum logic {IDLE, ACTIVE} serf_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop with registered rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta1;
  logic meta2;
  logic hist;

  // Reset to the line's idle level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta1 <= RST_VAL;
      meta2 <= RST_VAL;
      hist  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta1 <= din;
      meta2 <= meta1;
      hist  <= meta2;
      rise  <= meta2 & ~hist;
      fall  <= ~meta2 & hist;
    end
  end

endmodule

// File: rtl/spi_serf.sv
// 16-bit SPI responder: SCLK idles high, MOSI sampled on rise, MISO shifted on fall.
module spi_serf
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  input  logic              clr_rdy,
  output logic              frm_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  serf_state_t state;
  serf_state_t state_next;

  logic ss_rise;
  logic ss_fall;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_meta;
  logic mosi_sync;
  logic mosi_smpl;
  logic seen_rise;
  logic [CNT_W-1:0]  rise_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shifted;

  logic load;
  logic sample;
  logic shift_en;
  logic good;
  logic bad;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // End of frame takes priority over any SCLK edge landing in the same cycle.
  always_comb begin
    load     = 1'b0;
    sample   = 1'b0;
    shift_en = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE: load = ss_fall;
      ACTIVE: begin
        if (ss_rise) begin
          good = (rise_cnt == CNT_FULL);
          bad  = (rise_cnt != CNT_FULL);
        end else begin
          sample   = sclk_rise;
          shift_en = sclk_fall & seen_rise;
        end
      end
      default: ;
    endcase
  end

  assign shifted = {shift_reg[DATA_W-2:0], mosi_smpl};
  assign MISO    = shift_reg[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      rise_cnt  <= '0;
      seen_rise <= 1'b0;
      mosi_smpl <= 1'b0;
    end else if (load) begin
      shift_reg <= tx_data;
      rise_cnt  <= '0;
      seen_rise <= 1'b0;
    end else begin
      if (good || shift_en) shift_reg <= shifted;
      if (sample) begin
        mosi_smpl <= mosi_sync;
        seen_rise <= 1'b1;
        if (rise_cnt != CNT_SAT) rise_cnt <= rise_cnt + 1'b1;
      end
    end
  end

  // A completed frame sets rdy even if clr_rdy arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= bad;
      if (good) begin
        rx_data <= shifted;
        rdy     <= 1'b1;
      end else if (load || clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule
